// File: rtl/daq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : daq_pkg
// Description : Shared definitions for the DAQ frame builder: frame and
//               L1A-counter widths, header marker and FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package daq_pkg;

  localparam int FRAME_W   = 16;
  localparam int L1A_CNT_W = 12;
  localparam int PEND_W    = 4;   // holds the largest legal pending depth (15)
  localparam int WCNT_W    = 10;  // holds the largest legal data-word index

  localparam logic [3:0] HDR_MARK = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_TRL  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // True while a frame occupies the bus (header, payload or trailer).
  function automatic logic in_frame(input state_t s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_TRL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/l1a_pend_ctr.sv
`default_nettype none
// ============================================================================
// Module      : l1a_pend_ctr
// Description : Pending matched-L1A bookkeeping: pending counter, running
//               L1A counter, sticky overflow flag, overlap flags and the
//               event number of the frame being started.
// Ports       : i_clk, i_rst_n   - clock, async active-low reset
//               i_match          - matched L1A strobe
//               i_start          - frame start strobe (IDLE->HDR)
//               i_in_frame       - FSM currently in HDR/DATA/TRL
//               o_pending        - registered pending count
//               o_l1a_cnt        - matched-L1A counter (wraps)
//               o_evnum          - event number of a frame starting now
//               o_ovf            - sticky dropped-L1A flag
//               o_ovlp_mux/o_mlt_ovlp - registered overlap flags
// Revision    : 1.0 - initial release
// ============================================================================
module l1a_pend_ctr
  import daq_pkg::*;
#(
  parameter int MAXPEND = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_match,
  input  logic                 i_start,
  input  logic                 i_in_frame,
  output logic [PEND_W-1:0]    o_pending,
  output logic [L1A_CNT_W-1:0] o_l1a_cnt,
  output logic [L1A_CNT_W-1:0] o_evnum,
  output logic                 o_ovf,
  output logic                 o_ovlp_mux,
  output logic                 o_mlt_ovlp
);

  localparam logic [PEND_W-1:0] c_MAXPEND = PEND_W'(MAXPEND);

  logic [PEND_W-1:0]    r_pend;
  logic [L1A_CNT_W-1:0] r_cnt;
  logic                 r_ovf;
  logic                 r_ovlp;
  logic                 r_mlt;

  logic [PEND_W-1:0]    w_pend_nxt;
  logic [L1A_CNT_W-1:0] w_cnt_nxt;
  logic                 w_drop;

  always_comb begin
    w_pend_nxt = r_pend;
    w_cnt_nxt  = r_cnt;
    w_drop     = 1'b0;
    if (i_match) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
    // A match coinciding with a start replaces the dequeued event, so the
    // queue depth is unchanged and nothing can be dropped.
    if (i_start && !i_match) begin
      w_pend_nxt = r_pend - 1'b1;
    end else if (i_match && !i_start) begin
      if (r_pend < c_MAXPEND) begin
        w_pend_nxt = r_pend + 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end
  end

  // Post-update count minus post-update backlog is the number of the event
  // being dequeued, including the case where the starting event arrives now.
  assign o_evnum = w_cnt_nxt - {{(L1A_CNT_W-PEND_W){1'b0}}, w_pend_nxt};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_ovlp <= 1'b0;
      r_mlt  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
      r_ovf  <= r_ovf | w_drop;
      r_ovlp <= i_in_frame && (w_pend_nxt != '0);
      r_mlt  <= i_in_frame && (w_pend_nxt >= PEND_W'(2));
    end
  end

  assign o_pending  = r_pend;
  assign o_l1a_cnt  = r_cnt;
  assign o_ovf      = r_ovf;
  assign o_ovlp_mux = r_ovlp;
  assign o_mlt_ovlp = r_mlt;

endmodule
`default_nettype wire

// File: rtl/daq_frame_builder.sv
`default_nettype none
// ============================================================================
// Module      : daq_frame_builder
// Description : Builds one frame (header, NWORDS samples, checksum trailer)
//               per matched L1A from an FWFT sample FIFO and drives the
//               channel-link output stage. Matched L1As arriving during a
//               frame are queued and flagged as overlaps.
// Ports       : CLK, RST_B          - clock, async active-low reset
//               L1A, L1A_MATCH_IN   - trigger strobe and its qualifier
//               SMP_DATA, SMP_EMPTY - FWFT FIFO head word / empty
//               SMP_RE              - FIFO pop (combinational)
//               FRAME_DATA, DVALID, LAST_WRD, L1A_MATCH - registered frame bus
//               OVLP_MUX, MLT_OVLP  - registered overlap flags
//               L1A_CNT, OVF        - matched-L1A count, sticky drop flag
// Revision    : 1.0 - initial release
// ============================================================================
module daq_frame_builder
  import daq_pkg::*;
#(
  parameter int NWORDS  = 96,
  parameter int MAXPEND = 7
) (
  input  logic                 CLK,
  input  logic                 RST_B,
  input  logic                 L1A,
  input  logic                 L1A_MATCH_IN,
  input  logic [FRAME_W-1:0]   SMP_DATA,
  input  logic                 SMP_EMPTY,
  output logic                 SMP_RE,
  output logic [FRAME_W-1:0]   FRAME_DATA,
  output logic                 DVALID,
  output logic                 LAST_WRD,
  output logic                 L1A_MATCH,
  output logic                 OVLP_MUX,
  output logic                 MLT_OVLP,
  output logic [L1A_CNT_W-1:0] L1A_CNT,
  output logic                 OVF
);

  localparam logic [WCNT_W-1:0] c_LAST_IDX = WCNT_W'(NWORDS - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [FRAME_W-1:0]   r_csum;
  logic [WCNT_W-1:0]    r_wcnt;
  logic [L1A_CNT_W-1:0] r_evnum;

  logic                 w_match;
  logic                 w_start;
  logic                 w_pop;
  logic [PEND_W-1:0]    w_pending;
  logic [L1A_CNT_W-1:0] w_evnum;

  logic [FRAME_W-1:0]   w_data_nxt;
  logic                 w_dvalid_nxt;
  logic                 w_last_nxt;
  logic                 w_hmatch_nxt;

  assign w_match = L1A & L1A_MATCH_IN;
  assign w_start = (r_state == ST_IDLE) && ((w_pending != '0) || w_match);
  assign w_pop   = (r_state == ST_DATA) && !SMP_EMPTY;
  assign SMP_RE  = w_pop;

  l1a_pend_ctr #(
    .MAXPEND (MAXPEND)
  ) u_pend (
    .i_clk      (CLK),
    .i_rst_n    (RST_B),
    .i_match    (w_match),
    .i_start    (w_start),
    .i_in_frame (in_frame(r_state)),
    .o_pending  (w_pending),
    .o_l1a_cnt  (L1A_CNT),
    .o_evnum    (w_evnum),
    .o_ovf      (OVF),
    .o_ovlp_mux (OVLP_MUX),
    .o_mlt_ovlp (MLT_OVLP)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_HDR;
      ST_HDR:  w_state_nxt = ST_DATA;
      ST_DATA: if (w_pop && (r_wcnt == c_LAST_IDX)) w_state_nxt = ST_TRL;
      ST_TRL:  w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Decoded from the current state and registered below, so every bus word
  // appears one cycle after the state that produced it.
  always_comb begin
    w_data_nxt   = FRAME_DATA;
    w_dvalid_nxt = 1'b0;
    w_last_nxt   = 1'b0;
    w_hmatch_nxt = 1'b0;
    case (r_state)
      ST_HDR: begin
        w_data_nxt   = {HDR_MARK, r_evnum};
        w_dvalid_nxt = 1'b1;
        w_hmatch_nxt = 1'b1;
      end
      ST_DATA: begin
        if (w_pop) begin
          w_data_nxt   = SMP_DATA;
          w_dvalid_nxt = 1'b1;
        end
      end
      ST_TRL: begin
        w_data_nxt   = r_csum;
        w_dvalid_nxt = 1'b1;
        w_last_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      FRAME_DATA <= '0;
      DVALID     <= 1'b0;
      LAST_WRD   <= 1'b0;
      L1A_MATCH  <= 1'b0;
    end else begin
      FRAME_DATA <= w_data_nxt;
      DVALID     <= w_dvalid_nxt;
      LAST_WRD   <= w_last_nxt;
      L1A_MATCH  <= w_hmatch_nxt;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_csum  <= '0;
      r_wcnt  <= '0;
      r_evnum <= '0;
    end else begin
      if (w_start) begin
        r_evnum <= w_evnum;
      end
      if (r_state == ST_HDR) begin
        r_csum <= '0;
        r_wcnt <= '0;
      end else if (w_pop) begin
        r_csum <= r_csum + SMP_DATA;  // carry out discarded
        r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/daq_frame_builder.md
Name: daq_frame_builder

Overview:
- Builds one DAQ frame per matched L1A and drives the channel-link output stage (FRAME_DATA, DVALID, LAST_WRD, L1A_MATCH, OVLP_MUX, MLT_OVLP).
- Sits directly upstream of the channel-link output stage. Reads digitized sample words from a first-word-fall-through (FWFT) sample FIFO.
- Frame format: one header word, NWORDS data words, one checksum trailer word.
- Queues matched L1As that arrive while a frame is being sent, and flags those overlaps.

Parameters:
NWORDS, 96, data words per frame (legal range 1..1023)
MAXPEND, 7, depth of the pending-L1A counter (legal range 1..15)

Ports:
CLK  input  1  system clock; all logic on rising edge
RST_B  input  1  asynchronous active-low reset
L1A  input  1  one-cycle L1A strobe
L1A_MATCH_IN  input  1  qualifies L1A; valid in the same cycle as L1A
SMP_DATA  input  16  FWFT sample FIFO head word
SMP_EMPTY  input  1  sample FIFO empty
SMP_RE  output  1  sample FIFO read/pop; asserted only when SMP_EMPTY=0
FRAME_DATA  output  16  frame word to the link stage
DVALID  output  1  FRAME_DATA valid this cycle
LAST_WRD  output  1  marks the trailer word
L1A_MATCH  output  1  one-cycle pulse coincident with the header word
OVLP_MUX  output  1  frame in progress with pending>=1
MLT_OVLP  output  1  frame in progress with pending>=2
L1A_CNT  output  12  matched-L1A counter
OVF  output  1  sticky: matched L1A dropped because the queue was full

Behaviour:
- Reset (asynchronous, RST_B=0):
  - All outputs 0; FSM goes to IDLE.
  - pending=0, L1A_CNT=0, checksum=0, word counter=0, OVF=0.
  - A reset mid-frame aborts the frame: no trailer, LAST_WRD is not asserted.
- Matched L1A means L1A=1 and L1A_MATCH_IN=1 in the same cycle. L1A=1 with L1A_MATCH_IN=0 is ignored.
- On a matched L1A:
  - L1A_CNT increments, wrapping 4095->0.
  - If pending<MAXPEND: pending+1. Otherwise the L1A is dropped, OVF is set and stays set until reset. L1A_CNT still increments when the L1A is dropped.
- A frame start (IDLE->HDR) decrements pending.
  - A matched L1A in the same cycle as a frame start leaves pending unchanged.
  - That matched L1A is not treated as a drop even when pending==MAXPEND.
- The header carries the L1A_CNT value captured at the frame start, i.e. the count of the dequeued event. A FIFO of L1A numbers is not required: the header number = L1A_CNT - pending at the start, in mod-4096 arithmetic.
- FSM states: IDLE, HDR, DATA, TRL, GAP.
  - IDLE: go to HDR when pending>0 (registered value), or when a matched L1A arrives this cycle.
  - HDR (1 cycle): FRAME_DATA={4'hA, evnum[11:0]}, DVALID=1, L1A_MATCH=1. Clear checksum and word counter.
  - DATA:
    - Each cycle with SMP_EMPTY=0: SMP_RE=1, FRAME_DATA=SMP_DATA, DVALID=1, checksum+=SMP_DATA (mod 2^16), word counter+1.
    - Cycle with SMP_EMPTY=1: stall. DVALID=0, SMP_RE=0, FRAME_DATA holds its last value.
    - After NWORDS words have been sent: go to TRL.
  - TRL (1 cycle): FRAME_DATA=checksum (sum of the NWORDS data words only), DVALID=1, LAST_WRD=1.
  - GAP (1 cycle): DVALID=0, then IDLE. This gives a minimum one-cycle gap between frames.
- Output registering and latency:
  - FRAME_DATA, DVALID, LAST_WRD, L1A_MATCH, OVLP_MUX and MLT_OVLP are registered.
  - SMP_RE is combinational from state and SMP_EMPTY. The word popped in cycle t appears on FRAME_DATA in cycle t+1.
  - Latency: a matched L1A at cycle t with pending=0 and the FSM in IDLE gives the header word on FRAME_DATA at t+2.
- OVLP_MUX and MLT_OVLP:
  - Evaluated from the next-state pending value.
  - Asserted only while the FSM is in HDR, DATA or TRL.
  - Deasserted in GAP and IDLE.
- Checksum wraps mod 2^16; a carry out is discarded.
- DVALID and LAST_WRD are never 1 outside the states listed above.

Decomposition:
- Shared package daq_pkg holds:
  - the FSM state encoding (3-bit);
  - the header marker constant HDR_MARK=4'hA;
  - the widths: FRAME_W=16, L1A_CNT_W=12.
- Natural sub-module: l1a_pend_ctr. It contains the pending counter, L1A_CNT, the OVF logic and the overlap flag generation. Inputs: the matched-L1A strobe and the frame-start strobe.
- The FSM, checksum and word counter stay in daq_frame_builder.

Test Plan:
1. NWORDS=4, FIFO preloaded with 0x0001..0x0004, one matched L1A:
   - Words on the bus: 0xA001, 0x0001, 0x0002, 0x0003, 0x0004, 0x000A.
   - LAST_WRD only on 0x000A; L1A_MATCH only on 0xA001.
   - Header appears 2 cycles after the L1A.
2. Unmatched L1A (L1A_MATCH_IN=0) -> no frame; L1A_CNT stays 0.
3. Three matched L1As within the first frame:
   - MLT_OVLP=1 and OVLP_MUX=1 during frame 1.
   - Frames 2 and 3 follow, with headers 0xA002 and 0xA003, each after a 1-cycle gap.
   - During frame 3: OVLP_MUX=0.
4. SMP_EMPTY=1 for 3 cycles mid-DATA:
   - DVALID=0 for those 3 cycles, then the frame resumes.
   - Checksum and word count are unaffected.
5. MAXPEND=2 with 4 back-to-back matched L1As while the FSM is held in DATA by SMP_EMPTY=1:
   - The 4th L1A is dropped: OVF=1, L1A_CNT=4.
   - Exactly 3 frames are emitted in total: the one in progress plus 2 queued.
6. RST_B pulsed low mid-DATA:
   - All outputs go to 0 immediately; no LAST_WRD is emitted.
   - After release, a new matched L1A produces header 0xA001.
